// File: rtl/uart_rx_core_if.sv
// Byte stream handshake between the receiver FIFO head and its consumer.
// The master side presents data/valid; the slave side returns ready.
interface uart_rx_core_if;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;

    modport master (output rx_data_o, output rx_valid_o, input rx_ready_i);
    modport slave  (input rx_data_o, input rx_valid_o, output rx_ready_i);
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// first-word-fall-through byte FIFO with sticky framing/overrun/parity flags.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 4167,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          rx_i,
    uart_rx_core_if.master                rx_if,
    output logic                          rx_busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    output logic                          parity_err_o,
    input  logic                          err_clr_i
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic          r_sync1, r_sync2;
    logic          w_rx;
    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [2:0]    r_bit, w_bit_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          w_push, w_set_frame;
`ifdef UART_RX_PARITY_EN
    logic          r_par_bad, w_par_bad_next;
    logic          w_set_par;
    logic          r_parity_err;
`endif

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_full, w_valid, w_pop, w_do_push, w_overrun;
    logic          r_frame_err, r_overrun;

    // Both synchronizer flops reset to idle-high so reset never looks like a start bit.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rx = r_sync2;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_next;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_push       = 1'b0;
        w_set_frame  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_next = r_par_bad;
        w_set_par      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (!w_rx) w_state_next = S_START;
            end
            S_START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = w_rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next   = '0;
                    w_shift_next = {w_rx, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next     = '0;
                    w_par_bad_next = (w_rx != ^r_shift);
                    w_state_next   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next = '0;
                    if (!w_rx) begin
                        w_set_frame  = 1'b1;
                        w_state_next = S_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (r_par_bad) begin
                        w_set_par    = 1'b1;
                        w_state_next = S_IDLE;
`endif
                    end else begin
                        w_push       = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                w_cnt_next = '0;
                if (w_rx) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_full    = (r_count == DEPTH_C);
    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid & rx_if.rx_ready_i;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_do_push = w_push & (~w_full | w_pop);
    assign w_overrun = w_push & w_full & ~w_pop;

    always_ff @(posedge wb_clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: a new error in the same cycle as a clear wins.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_set_frame | (r_frame_err & ~err_clr_i);
            r_overrun   <= w_overrun   | (r_overrun   & ~err_clr_i);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_parity_err <= 1'b0;
        else          r_parity_err <= w_set_par | (r_parity_err & ~err_clr_i);
    end
    assign parity_err_o = r_parity_err;
`else
    assign parity_err_o = 1'b0;
`endif

    assign rx_if.rx_data_o  = w_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign rx_if.rx_valid_o = w_valid;
    assign rx_busy_o        = (r_state != S_IDLE);
    assign fifo_count_o     = r_count;
    assign frame_err_o      = r_frame_err;
    assign overrun_o        = r_overrun;
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial UART receiver with a small first-word-fall-through byte FIFO, placed in the user project on the receive pad (mprj_io[5]). It recovers 8-bit frames from the asynchronous line, buffers them, and presents them to the Wishbone-side register logic through a valid/ready handshake. Sticky error flags report framing and overrun errors to firmware.

## Interface
- CLKS_PER_BIT, 4167: clock cycles per bit, 40 MHz / 9600 baud; minimum 8.
- FIFO_DEPTH, 4: FIFO entries; must be a power of two, at least 2.
- wb_clk_i  in  1  system clock; the only clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- rx_i  in  1  asynchronous serial input; idles high.
- rx_data_o  out  8  FIFO head byte; valid only while rx_valid_o is high.
- rx_valid_o  out  1  FIFO not empty.
- rx_ready_i  in  1  consumer pop request.
- rx_busy_o  out  1  frame in progress (FSM not IDLE).
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- frame_err_o  out  1  sticky: stop bit sampled low.
- overrun_o  out  1  sticky: byte dropped because FIFO was full.
- parity_err_o  out  1  sticky: parity mismatch; constant 0 without UART_RX_PARITY_EN.
- err_clr_i  in  1  clears all sticky flags.

## Operation
- rx_i passes through a 2-flop synchronizer; both flops reset to 1. The FSM sees only the synchronized value.
- Bit counter: 0..CLKS_PER_BIT-1. Bit index: 0..7.
- IDLE: a synchronized 0 moves the FSM to START and clears the counter.
- START: at count CLKS_PER_BIT/2-1 (integer division), sample the line.
  - Line 0: go to DATA and clear the counter.
  - Line 1: glitch; return to IDLE with no flag set.
- DATA: sample when count reaches CLKS_PER_BIT-1, so each sample falls at bit mid-point.
  - Shift right, inserting at bit 7, so the byte is received LSB first.
  - After bit 7, go to STOP, or to PARITY when the macro is defined.
- PARITY (macro only): sample once and compare with even parity of the received byte.
- STOP: sample at CLKS_PER_BIT-1.
  - Line 1 and no parity error: push the byte, then go to IDLE.
  - Line 0: set frame_err_o, discard the byte, go to BREAK.
  - Parity error: set parity_err_o, discard the byte, go to IDLE.
- BREAK: wait for a synchronized 1, then go to IDLE. A held-low line therefore never retriggers the receiver.
- FIFO: circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - Pop when rx_valid_o and rx_ready_i are both high.
  - Push while full with no pop in the same cycle: drop the byte and set overrun_o.
  - Push and pop in the same cycle while full: both succeed; no overrun; count unchanged.
  - Push and pop in the same cycle while empty: push only; pop is suppressed because valid is low.
- Sticky flags: err_clr_i clears them. When a set and err_clr_i occur in the same cycle, the set wins.

## Timing
- Reset values:
  - FSM in IDLE; FIFO empty.
  - rx_data_o=0, rx_valid_o=0, rx_busy_o=0, fifo_count_o=0, all flags 0.
  - wb_rst_i asserted mid-frame aborts the frame; the partial byte is lost.
- Synchronizer latency: 2 cycles from a pad edge to FSM visibility.
- rx_busy_o rises the cycle after IDLE sees the start edge. It falls the cycle after the STOP sample, or on leaving BREAK.
- Push occurs at the STOP sample edge. rx_valid_o and fifo_count_o update on the following cycle.
- The byte is available (2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1) cycles after the start edge reaches the pin, plus one bit period with parity.
- Pop is combinational from the handshake. The FIFO head advances on the next edge. Sustained throughput is 1 byte per cycle.

## Configuration
- UART_RX_PARITY_EN defined: frame is 8E1. The PARITY state exists and parity_err_o is live.
- UART_RX_PARITY_EN undefined: frame is 8N1. The PARITY state is absent and parity_err_o is tied 0.

## Test plan
All scenarios use CLKS_PER_BIT=16 and FIFO_DEPTH=4.
- Send 0x3D (8N1) with rx_ready_i=1 → rx_valid_o pulses for 1 cycle with rx_data_o=0x3D. No flags set.
- Send 0x0A, 0x55, 0xA5, 0xFF, 0x00 with rx_ready_i=0 → fifo_count_o=4 and overrun_o=1. Subsequent pops return 0x0A, 0x55, 0xA5, 0xFF, then rx_valid_o=0.
- Drive rx_i low for 4 cycles, then high → no push, rx_busy_o returns to 0, no flags.
- Send 0x3D with stop bit 0 and hold the line low 40 cycles → frame_err_o=1, count 0. Then raise err_clr_i and send 0x3D → flag cleared, 0x3D received.
- Assert wb_rst_i during data bit 4 → next cycle rx_busy_o=0 and count 0. A following 0x61 frame is received correctly.
- With UART_RX_PARITY_EN defined:
  - Send 0x3D with parity bit 1 → accepted.
  - Send 0x3D with parity bit 0 → parity_err_o=1 and the byte is not pushed.
